// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the cache/IO requesters, the arbiter and the
// byte-serial memory controller. The master view is the arbiter itself.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                  ic_valid;
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  ic_ready;
    logic [LINE_WIDTH-1:0] ic_rdata;

    logic                  dc_valid;
    logic                  dc_rw;
    logic [ADDR_WIDTH-1:0] dc_addr;
    logic [LINE_WIDTH-1:0] dc_wdata;
    logic                  dc_ready;
    logic [LINE_WIDTH-1:0] dc_rdata;

    logic                  io_valid;
    logic                  io_rw;
    logic [ADDR_WIDTH-1:0] io_addr;
    logic [7:0]            io_wdata;
    logic                  io_ready;
    logic [7:0]            io_rdata;

    logic                  mc_valid;
    logic [1:0]            mc_src;
    logic                  mc_rw;
    logic [ADDR_WIDTH-1:0] mc_addr;
    logic [LINE_WIDTH-1:0] mc_wdata;
    logic                  mc_done;
    logic [LINE_WIDTH-1:0] mc_rdata;

    modport master (
        input  ic_valid, ic_addr,
        input  dc_valid, dc_rw, dc_addr, dc_wdata,
        input  io_valid, io_rw, io_addr, io_wdata,
        input  mc_done, mc_rdata,
        output ic_ready, ic_rdata, dc_ready, dc_rdata, io_ready, io_rdata,
        output mc_valid, mc_src, mc_rw, mc_addr, mc_wdata
    );

    modport slave (
        output ic_valid, ic_addr,
        output dc_valid, dc_rw, dc_addr, dc_wdata,
        output io_valid, io_rw, io_addr, io_wdata,
        output mc_done, mc_rdata,
        input  ic_ready, ic_rdata, dc_ready, dc_rdata, io_ready, io_rdata,
        input  mc_valid, mc_src, mc_rw, mc_addr, mc_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Grants one of icache/dcache/IO to the memory controller at a time, holds the
// grant until mc_done, then pulses the owner's ready with the returned data.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] SRC_IC = 2'd0;
    localparam logic [1:0] SRC_DC = 2'd1;
    localparam logic [1:0] SRC_IO = 2'd2;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  mc_valid_q, mc_valid_d;
    logic [1:0]            mc_src_q, mc_src_d;
    logic                  mc_rw_q, mc_rw_d;
    logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
    logic [LINE_WIDTH-1:0] mc_wdata_q, mc_wdata_d;
    logic                  ic_ready_q, ic_ready_d;
    logic                  dc_ready_q, dc_ready_d;
    logic                  io_ready_q, io_ready_d;
    logic [LINE_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_WIDTH-1:0] dc_rdata_q, dc_rdata_d;
    logic [7:0]            io_rdata_q, io_rdata_d;
    logic                  last_cache_q, last_cache_d;  // 0 = icache, 1 = dcache
    logic [1:0]            io_streak_q, io_streak_d;

    logic ic_req, dc_req, io_req, cache_req;
    logic grant_ic, grant_dc, grant_io;

    always_comb begin
        // The owner just served is still in RESP and may not have dropped valid yet.
        ic_req    = bus.ic_valid && !(state_q == RESP && mc_src_q == SRC_IC);
        dc_req    = bus.dc_valid && !(state_q == RESP && mc_src_q == SRC_DC);
        io_req    = bus.io_valid && !(state_q == RESP && mc_src_q == SRC_IO);
        cache_req = ic_req || dc_req;
        grant_io  = io_req && !(io_streak_q == 2'd3 && cache_req);
        grant_ic  = !grant_io && ic_req && (!dc_req || last_cache_q);
        grant_dc  = !grant_io && dc_req && (!ic_req || !last_cache_q);
    end

    always_comb begin
        state_d      = state_q;
        mc_valid_d   = mc_valid_q;
        mc_src_d     = mc_src_q;
        mc_rw_d      = mc_rw_q;
        mc_addr_d    = mc_addr_q;
        mc_wdata_d   = mc_wdata_q;
        ic_ready_d   = 1'b0;
        dc_ready_d   = 1'b0;
        io_ready_d   = 1'b0;
        ic_rdata_d   = ic_rdata_q;
        dc_rdata_d   = dc_rdata_q;
        io_rdata_d   = io_rdata_q;
        last_cache_d = last_cache_q;
        io_streak_d  = io_streak_q;

        case (state_q)
            BUSY: begin
                if (bus.mc_done) begin
                    mc_valid_d = 1'b0;
                    state_d    = RESP;
                    case (mc_src_q)
                        SRC_IC: begin
                            ic_ready_d = 1'b1;
                            if (!mc_rw_q) ic_rdata_d = bus.mc_rdata;
                        end
                        SRC_DC: begin
                            dc_ready_d = 1'b1;
                            if (!mc_rw_q) dc_rdata_d = bus.mc_rdata;
                        end
                        default: begin
                            io_ready_d = 1'b1;
                            if (!mc_rw_q) io_rdata_d = bus.mc_rdata[7:0];
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
                if (grant_io || grant_ic || grant_dc) begin
                    state_d    = BUSY;
                    mc_valid_d = 1'b1;
                end
                if (grant_io) begin
                    mc_src_d    = SRC_IO;
                    mc_rw_d     = bus.io_rw;
                    mc_addr_d   = bus.io_addr;
                    mc_wdata_d  = {{(LINE_WIDTH-8){1'b0}}, bus.io_wdata};
                    io_streak_d = !cache_req ? 2'd0 :
                                  (io_streak_q == 2'd3) ? 2'd3 : io_streak_q + 2'd1;
                end else if (grant_ic) begin
                    mc_src_d     = SRC_IC;
                    mc_rw_d      = 1'b0;
                    mc_addr_d    = bus.ic_addr;
                    mc_wdata_d   = '0;
                    io_streak_d  = 2'd0;
                    last_cache_d = 1'b0;
                end else if (grant_dc) begin
                    mc_src_d     = SRC_DC;
                    mc_rw_d      = bus.dc_rw;
                    mc_addr_d    = bus.dc_addr;
                    mc_wdata_d   = bus.dc_wdata;
                    io_streak_d  = 2'd0;
                    last_cache_d = 1'b1;
                end
            end
        endcase
    end

    // While rdy is low everything holds, except that ready pulses are not extended.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mc_valid_q   <= 1'b0;
            mc_src_q     <= SRC_IC;
            mc_rw_q      <= 1'b0;
            mc_addr_q    <= '0;
            mc_wdata_q   <= '0;
            ic_ready_q   <= 1'b0;
            dc_ready_q   <= 1'b0;
            io_ready_q   <= 1'b0;
            ic_rdata_q   <= '0;
            dc_rdata_q   <= '0;
            io_rdata_q   <= '0;
            last_cache_q <= 1'b1;
            io_streak_q  <= 2'd0;
        end else if (rdy) begin
            state_q      <= state_d;
            mc_valid_q   <= mc_valid_d;
            mc_src_q     <= mc_src_d;
            mc_rw_q      <= mc_rw_d;
            mc_addr_q    <= mc_addr_d;
            mc_wdata_q   <= mc_wdata_d;
            ic_ready_q   <= ic_ready_d;
            dc_ready_q   <= dc_ready_d;
            io_ready_q   <= io_ready_d;
            ic_rdata_q   <= ic_rdata_d;
            dc_rdata_q   <= dc_rdata_d;
            io_rdata_q   <= io_rdata_d;
            last_cache_q <= last_cache_d;
            io_streak_q  <= io_streak_d;
        end else begin
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
            io_ready_q <= 1'b0;
        end
    end

    assign bus.mc_valid = mc_valid_q;
    assign bus.mc_src   = mc_src_q;
    assign bus.mc_rw    = mc_rw_q;
    assign bus.mc_addr  = mc_addr_q;
    assign bus.mc_wdata = mc_wdata_q;
    assign bus.ic_ready = ic_ready_q;
    assign bus.dc_ready = dc_ready_q;
    assign bus.io_ready = io_ready_q;
    assign bus.ic_rdata = ic_rdata_q;
    assign bus.dc_rdata = dc_rdata_q;
    assign bus.io_rdata = io_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model of the grant rules (priority, round-robin, IO streak limit).
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) bus ();
    mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: who won the last cache grant, IO streak, last returned data.
    int           streak_m;
    int           last_m;   // 0 = icache, 1 = dcache
    logic [127:0] exp_ic_rd, exp_dc_rd;
    logic [7:0]   exp_io_rd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // excl = requester still finishing its response (-1 when none).
    function automatic int model_pick(bit ic, bit dc, bit io, int excl);
        bit icw = ic && excl != 0;
        bit dcw = dc && excl != 1;
        bit iow = io && excl != 2;
        if (iow && !(streak_m == 3 && (icw || dcw))) return 2;
        if (icw && dcw) return (last_m == 1) ? 0 : 1;
        if (icw) return 0;
        if (dcw) return 1;
        return -1;
    endfunction

    function automatic bit model_cache_wait(bit ic, bit dc, int excl);
        return (ic && excl != 0) || (dc && excl != 1);
    endfunction

    task automatic model_commit(input int w, input bit cache_wait);
        if (w == 2) streak_m = cache_wait ? ((streak_m == 3) ? 3 : streak_m + 1) : 0;
        else begin
            streak_m = 0;
            last_m   = w;
        end
    endtask

    task automatic clear_inputs();
        bus.ic_valid = 0; bus.dc_valid = 0; bus.io_valid = 0;
        bus.dc_rw = 0; bus.io_rw = 0; bus.mc_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        streak_m = 0; last_m = 1;
        exp_ic_rd = '0; exp_dc_rd = '0; exp_io_rd = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mc_valid"}, 128'(bus.mc_valid), 128'(0));
        check({tag, "_mc_src"},   128'(bus.mc_src),   128'(0));
        check({tag, "_mc_rw"},    128'(bus.mc_rw),    128'(0));
        check({tag, "_mc_addr"},  128'(bus.mc_addr),  128'(0));
        check({tag, "_mc_wdata"}, bus.mc_wdata,       128'(0));
        check({tag, "_readies"},  128'({bus.ic_ready, bus.dc_ready, bus.io_ready}), 128'(0));
        check({tag, "_ic_rdata"}, bus.ic_rdata, 128'(0));
        check({tag, "_dc_rdata"}, bus.dc_rdata, 128'(0));
        check({tag, "_io_rdata"}, 128'(bus.io_rdata), 128'(0));
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (bus.mc_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check({tag, "_grant_timeout"}, 128'(bus.mc_valid), 128'(1));
    endtask

    task automatic complete(input logic [127:0] rdata);
        bus.mc_rdata = rdata;
        bus.mc_done  = 1;
        tick();
        bus.mc_done  = 0;
    endtask

    // Requests held constant; checks each grant's owner and the one-cycle gap.
    task automatic run_chain(input string tag, input bit ic, input bit dc, input bit io, input int n);
        int excl = -1;
        int w;
        int nxt;
        bus.ic_valid = ic; bus.dc_valid = dc; bus.io_valid = io;
        bus.dc_rw = 0; bus.io_rw = 0;
        wait_grant(tag);
        for (int k = 0; k < n; k++) begin
            w = model_pick(ic, dc, io, excl);
            check({tag, "_src"}, 128'(bus.mc_src), 128'(w));
            model_commit(w, model_cache_wait(ic, dc, excl));
            $display("%s grant %0d: src=%0d", tag, k, bus.mc_src);
            tick(); tick();
            check({tag, "_hold"}, 128'(bus.mc_valid), 128'(1));
            complete(rnd128());
            check({tag, "_gap"}, 128'(bus.mc_valid), 128'(0));
            check({tag, "_ready"}, 128'({bus.ic_ready, bus.dc_ready, bus.io_ready}),
                  128'({w == 0, w == 1, w == 2}));
            excl = w;
            nxt = model_pick(ic, dc, io, excl);
            tick();
            check({tag, "_regrant"}, 128'(bus.mc_valid), 128'(nxt >= 0));
        end
        clear_inputs();
    endtask

    initial begin
        logic [127:0] line;
        logic [127:0] exp_wdata;
        logic [31:0]  exp_addr;
        logic         exp_rw;
        bit           v_ic, v_dc, v_io;
        int           w;
        bus.ic_addr = '0; bus.dc_addr = '0; bus.io_addr = '0;
        bus.dc_wdata = '0; bus.io_wdata = '0; bus.mc_rdata = '0;

        // Reset state
        do_reset();
        check_idle("reset");
        $display("reset: mc_valid=%0d", bus.mc_valid);

        // Single icache read
        bus.ic_valid = 1; bus.ic_addr = 32'h0000_1000;
        line = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        tick();
        check("ic_grant_valid", 128'(bus.mc_valid), 128'(1));
        check("ic_grant_src",   128'(bus.mc_src),   128'(0));
        check("ic_grant_rw",    128'(bus.mc_rw),    128'(0));
        check("ic_grant_addr",  128'(bus.mc_addr),  128'(32'h0000_1000));
        bus.ic_valid = 0;
        repeat (19) tick();
        check("ic_busy_hold", 128'(bus.mc_valid), 128'(1));
        complete(line);
        check("ic_ready",   128'(bus.ic_ready), 128'(1));
        check("ic_rdata",   bus.ic_rdata, line);
        check("ic_others",  128'({bus.dc_ready, bus.io_ready}), 128'(0));
        tick();
        check("ic_ready_once", 128'(bus.ic_ready), 128'(0));
        $display("ic read: rdata=%h", bus.ic_rdata);

        // icache/dcache round-robin
        do_reset();
        run_chain("rr", 1, 1, 0, 4);
        // all three requesting
        do_reset();
        run_chain("all", 1, 1, 1, 8);

        // dcache write: latched wdata must survive input changes
        do_reset();
        exp_wdata = {16{8'hA5}};
        bus.dc_valid = 1; bus.dc_rw = 1; bus.dc_addr = 32'h20; bus.dc_wdata = exp_wdata;
        tick();
        check("dcw_src", 128'(bus.mc_src), 128'(1));
        check("dcw_rw",  128'(bus.mc_rw),  128'(1));
        bus.dc_valid = 0; bus.dc_wdata = rnd128(); bus.dc_addr = $urandom;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dcw_wdata_hold", bus.mc_wdata, exp_wdata);
            check("dcw_addr_hold",  128'(bus.mc_addr), 128'(32'h20));
        end
        complete(rnd128() | 128'h1);
        check("dcw_ready", 128'(bus.dc_ready), 128'(1));
        check("dcw_rdata", bus.dc_rdata, 128'(0));
        tick();
        check("dcw_ready_once", 128'(bus.dc_ready), 128'(0));
        $display("dc write: wdata=%h", exp_wdata);

        // IO read, io_valid held through RESP
        bus.io_valid = 1; bus.io_rw = 0; bus.io_addr = 32'h0003_0000;
        tick();
        check("io_src",  128'(bus.mc_src),  128'(2));
        check("io_addr", 128'(bus.mc_addr), 128'(32'h0003_0000));
        repeat (3) tick();
        complete({rnd128()} & ~128'hFF | 128'h41);
        check("io_ready", 128'(bus.io_ready), 128'(1));
        check("io_rdata", 128'(bus.io_rdata), 128'(8'h41));
        check("io_resp_valid", 128'(bus.mc_valid), 128'(0));
        tick();
        check("io_no_regrant", 128'(bus.mc_valid), 128'(0));
        check("io_ready_once", 128'(bus.io_ready), 128'(0));
        bus.io_valid = 0;
        tick();
        $display("io read: rdata=%h", bus.io_rdata);

        // Reset during a dcache read
        do_reset();
        bus.dc_valid = 1; bus.dc_rw = 0; bus.dc_addr = $urandom;
        tick();
        check("rstb_src", 128'(bus.mc_src), 128'(1));
        bus.dc_valid = 0;
        repeat (3) tick();
        rst = 1; bus.mc_done = 1; bus.mc_rdata = rnd128();
        tick();
        rst = 0; bus.mc_done = 0;
        check_idle("rstb");
        tick();
        check("rstb_no_ready", 128'(bus.dc_ready), 128'(0));
        $display("reset mid-busy: mc_valid=%0d", bus.mc_valid);

        // rdy low mid-BUSY: everything holds, mc_done is lost
        do_reset();
        bus.ic_valid = 1; bus.ic_addr = 32'h4000_0040;
        tick();
        bus.ic_valid = 0;
        rdy = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ic_addr = $urandom;
            bus.mc_done = (i == 2);
            tick();
            check("rdy_valid_hold", 128'(bus.mc_valid), 128'(1));
            check("rdy_addr_hold",  128'(bus.mc_addr),  128'(32'h4000_0040));
            check("rdy_no_ready",   128'(bus.ic_ready), 128'(0));
        end
        rdy = 1; bus.mc_done = 0;
        tick();
        check("rdy_done_lost", 128'(bus.mc_valid), 128'(1));
        line = rnd128();
        complete(line);
        check("rdy_ready", 128'(bus.ic_ready), 128'(1));
        check("rdy_rdata", bus.ic_rdata, line);
        tick();
        $display("rdy stall: rdata=%h", bus.ic_rdata);

        // Randomized single-shot requests from IDLE
        do_reset();
        for (int it = 0; it < 60; it++) begin
            v_ic = 1'($urandom_range(0, 1));
            v_dc = 1'($urandom_range(0, 1));
            v_io = ($urandom_range(0, 3) != 0);
            bus.ic_valid = v_ic; bus.dc_valid = v_dc; bus.io_valid = v_io;
            bus.ic_addr = $urandom; bus.dc_addr = $urandom; bus.io_addr = $urandom;
            bus.dc_rw = 1'($urandom_range(0, 1)); bus.io_rw = 1'($urandom_range(0, 1));
            bus.dc_wdata = rnd128(); bus.io_wdata = 8'($urandom);
            w = model_pick(v_ic, v_dc, v_io, -1);
            case (w)
                0: begin exp_rw = 0; exp_addr = bus.ic_addr; exp_wdata = '0; end
                1: begin exp_rw = bus.dc_rw; exp_addr = bus.dc_addr; exp_wdata = bus.dc_wdata; end
                default: begin
                    exp_rw = bus.io_rw; exp_addr = bus.io_addr;
                    exp_wdata = {120'b0, bus.io_wdata};
                end
            endcase
            tick();
            clear_inputs();
            bus.dc_wdata = rnd128();
            check("rnd_valid", 128'(bus.mc_valid), 128'(w >= 0));
            $display("rnd %0d: req ic=%0d dc=%0d io=%0d exp_src=%0d got_src=%0d",
                     it, v_ic, v_dc, v_io, w, bus.mc_src);
            if (w < 0) continue;
            check("rnd_src",   128'(bus.mc_src),  128'(w));
            check("rnd_rw",    128'(bus.mc_rw),   128'(exp_rw));
            check("rnd_addr",  128'(bus.mc_addr), 128'(exp_addr));
            check("rnd_wdata", bus.mc_wdata,      exp_wdata);
            model_commit(w, v_ic || v_dc);
            repeat ($urandom_range(0, 4)) tick();
            line = rnd128();
            complete(line);
            if (!exp_rw) begin
                if (w == 0) exp_ic_rd = line;
                else if (w == 1) exp_dc_rd = line;
                else exp_io_rd = line[7:0];
            end
            check("rnd_ready", 128'({bus.ic_ready, bus.dc_ready, bus.io_ready}),
                  128'({w == 0, w == 1, w == 2}));
            check("rnd_ic_rdata", bus.ic_rdata, exp_ic_rd);
            check("rnd_dc_rdata", bus.dc_rdata, exp_dc_rd);
            check("rnd_io_rdata", 128'(bus.io_rdata), 128'(exp_io_rd));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
